// File: rtl/mchan_rr_arbiter_ipa.sv
// mchan_rr_arbiter_ipa: round-robin arbiter with per-requestor payload mux.
//
// Picks one of N_REQ requestors and forwards its payload downstream. The
// search starts at a rotating priority pointer, so every requestor is served
// in turn.
//
// Build option (macro MCHAN_ARB_OUT_REG_EN):
//   undefined : combinational datapath with zero latency. A stalled winner
//               (req_o=1, gnt_i=0) is locked so that the offered entry stays
//               stable until it transfers or its request drops.
//   defined   : a one-entry output register sits between the arbiter and the
//               downstream port. Upstream grants are issued whenever the
//               register is empty or being drained. The lock is not used.
//
// Ports:
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   req_i      : per-requestor request, N_REQ bits
//   data_i     : flattened payloads, requestor k at [k*DATA_WIDTH +: DATA_WIDTH]
//   gnt_o      : per-requestor grant, one-hot or zero
//   req_o      : downstream request
//   data_o     : payload of the current winner
//   id_o       : index of the current winner
//   gnt_i      : downstream grant; a transfer happens when req_o && gnt_i
module mchan_rr_arbiter_ipa #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_REQ-1:0]              req_i,
  input  logic [N_REQ*DATA_WIDTH-1:0]   data_i,
  output logic [N_REQ-1:0]              gnt_o,
  output logic                          req_o,
  output logic [DATA_WIDTH-1:0]         data_o,
  output logic [$clog2(N_REQ)-1:0]      id_o,
  input  logic                          gnt_i
);

  localparam int unsigned IDW = $clog2(N_REQ);

  logic [IDW-1:0]        ptr_q, ptr_d;
  logic [IDW-1:0]        rr_idx;
  logic [IDW-1:0]        win_idx;
  logic [IDW-1:0]        cand;
  logic                  found;
  logic                  any_req;
  logic [DATA_WIDTH-1:0] win_data;
  logic [N_REQ-1:0]      win_onehot;

  assign any_req = |req_i;

  // First requesting index at or after ptr; N_REQ is a power of two, so the
  // index wraps naturally in IDW bits.
  always_comb begin
    rr_idx = ptr_q;
    found  = 1'b0;
    cand   = ptr_q;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = ptr_q + IDW'(i);
      if (!found && req_i[cand]) begin
        found  = 1'b1;
        rr_idx = cand;
      end
    end
  end

  assign win_data   = data_i[32'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign win_onehot = N_REQ'(1) << win_idx;

`ifdef MCHAN_ARB_OUT_REG_EN

  logic                  out_vld_q, out_vld_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [IDW-1:0]        out_id_q, out_id_d;
  logic                  ready;
  logic                  take;

  assign win_idx = rr_idx;

  // Register can accept when empty or when its entry leaves this cycle.
  assign ready = ~out_vld_q | gnt_i;
  assign take  = any_req & ready;

  always_comb begin
    ptr_d      = ptr_q;
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    out_id_d   = out_id_q;
    if (ready) begin
      out_vld_d = any_req;
    end
    if (take) begin
      ptr_d      = win_idx + IDW'(1);
      out_data_d = win_data;
      out_id_d   = win_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_id_q   <= '0;
    end else begin
      ptr_q      <= ptr_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      out_id_q   <= out_id_d;
    end
  end

  assign gnt_o  = take ? win_onehot : '0;
  assign req_o  = out_vld_q;
  assign data_o = out_data_q;
  assign id_o   = out_id_q;

`else

  logic           lock_q, lock_d;
  logic [IDW-1:0] lock_idx_q, lock_idx_d;
  logic           lock_hit;
  logic           xfer;
  logic           req_c;

  // Lock only holds while the locked requestor still asks; otherwise normal
  // arbitration applies in the same cycle.
  assign lock_hit = lock_q & req_i[lock_idx_q];
  assign win_idx  = lock_hit ? lock_idx_q : rr_idx;

  // Reset discards any pending request immediately.
  assign req_c = any_req & rst_n;
  assign xfer  = req_c & gnt_i;

  always_comb begin
    ptr_d      = ptr_q;
    lock_d     = req_c & ~gnt_i;
    lock_idx_d = lock_idx_q;
    if (xfer) begin
      ptr_d = win_idx + IDW'(1);
    end
    if (lock_d) begin
      lock_idx_d = win_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  assign gnt_o  = xfer ? win_onehot : '0;
  assign req_o  = req_c;
  assign data_o = win_data;
  assign id_o   = win_idx;

`endif

endmodule

// File: tb/tb_mchan_rr_arbiter_ipa.sv
// Directed testbench for mchan_rr_arbiter_ipa (N_REQ=4, DATA_WIDTH=32).
// Payload of requestor k is 32'hA000_0000 + k.
module tb_mchan_rr_arbiter_ipa;

  localparam int unsigned N_REQ      = 4;
  localparam int unsigned DATA_WIDTH = 32;

  logic                        clk;
  logic                        rst_n;
  logic [N_REQ-1:0]            req_i;
  logic [N_REQ*DATA_WIDTH-1:0] data_i;
  logic [N_REQ-1:0]            gnt_o;
  logic                        req_o;
  logic [DATA_WIDTH-1:0]       data_o;
  logic [1:0]                  id_o;
  logic                        gnt_i;

  int n_vec;
  int n_err;

  mchan_rr_arbiter_ipa #(
    .N_REQ      (N_REQ),
    .DATA_WIDTH (DATA_WIDTH)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_i  (req_i),
    .data_i (data_i),
    .gnt_o  (gnt_o),
    .req_o  (req_o),
    .data_o (data_o),
    .id_o   (id_o),
    .gnt_i  (gnt_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs are then changed 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    rst_n  = 1'b0;
    req_i  = '0;
    gnt_i  = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      data_i[k*DATA_WIDTH +: DATA_WIDTH] = 32'hA000_0000 + 32'(k);
    end

    #2;
    chk("reset_req_o", 32'(req_o), 32'd0);
    chk("reset_gnt_o", 32'(gnt_o), 32'd0);
    chk("reset_id_o",  32'(id_o),  32'd0);
    tick();
    tick();
    rst_n = 1'b1;

`ifndef MCHAN_ARB_OUT_REG_EN
    // Full request, rotating ids 0,1,2,3 then wrap to 0.
    req_i = 4'b1111;
    gnt_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rr_id",   32'(id_o),   32'(k % 4));
      chk("rr_gnt",  32'(gnt_o),  32'd1 << (k % 4));
      chk("rr_data", data_o,      32'hA000_0000 + 32'(k % 4));
      tick();
    end
    // ptr = 1; a transfer from 1 moves it to 2.
    req_i = 4'b0010;
    #1; chk("ptr_to2_id", 32'(id_o), 32'd1); tick();
    // ptr = 2, req 1010 -> 3 wins, then 1.
    req_i = 4'b1010;
    #1; chk("p2_id",  32'(id_o),  32'd3);
        chk("p2_gnt", 32'(gnt_o), 32'b1000); tick();
    #1; chk("p0_id",  32'(id_o),  32'd1);
        chk("p0_gnt", 32'(gnt_o), 32'b0010); tick();
    // ptr = 2; idle must not move it.
    req_i = 4'b0000;
    #1; chk("idle_req_o", 32'(req_o), 32'd0);
        chk("idle_gnt",   32'(gnt_o), 32'd0); tick();
    tick();
    req_i = 4'b1011;
    #1; chk("hold_id", 32'(id_o), 32'd3); tick();
    // ptr = 0; single requestor granted every cycle.
    req_i = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      #1; chk("single_gnt", 32'(gnt_o), 32'b0010); tick();
    end
    // ptr = 2; a transfer from 3 wraps ptr to 0.
    req_i = 4'b1000;
    #1; chk("wrap_id", 32'(id_o), 32'd3); tick();
    // Lock on 2 while stalled, then req 0 arrives.
    req_i = 4'b0100;
    gnt_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1; chk("stall_id",    32'(id_o),  32'd2);
          chk("stall_req_o", 32'(req_o), 32'd1);
          chk("stall_gnt",   32'(gnt_o), 32'd0); tick();
    end
    req_i = 4'b0101;
    #1; chk("lock_id", 32'(id_o), 32'd2); tick();
    gnt_i = 1'b1;
    #1; chk("lock_gnt", 32'(gnt_o), 32'b0100);
        chk("lock_xid", 32'(id_o),  32'd2); tick();
    #1; chk("after_lock_id",  32'(id_o),  32'd0);
        chk("after_lock_gnt", 32'(gnt_o), 32'b0001); tick();
    // ptr = 1; lock on 2, then 2 drops while 1 requests.
    req_i = 4'b0100;
    gnt_i = 1'b0;
    #1; chk("lk2_id", 32'(id_o), 32'd2); tick();
    req_i = 4'b0110;
    #1; chk("lk2_hold_id", 32'(id_o), 32'd2); tick();
    req_i = 4'b0010;
    #1; chk("drop_id", 32'(id_o), 32'd1); tick();
    req_i = 4'b0110;
    #1; chk("drop_relock_id", 32'(id_o), 32'd1); tick();
    gnt_i = 1'b1;
    #1; chk("drop_gnt", 32'(gnt_o), 32'b0010); tick();
    // ptr = 2; lock on 2, then reset pulse.
    req_i = 4'b0100;
    gnt_i = 1'b0;
    #1; chk("pre_rst_id", 32'(id_o), 32'd2); tick();
    req_i = 4'b0101;
    gnt_i = 1'b1;
    rst_n = 1'b0;
    #1; chk("rst_req_o", 32'(req_o), 32'd0);
        chk("rst_gnt",   32'(gnt_o), 32'd0);
        chk("rst_id",    32'(id_o),  32'd0);
    tick();
    rst_n = 1'b1;
    #1; chk("post_rst_id",  32'(id_o),  32'd0);
        chk("post_rst_gnt", 32'(gnt_o), 32'b0001); tick();
`else
    // Empty register: upstream grant, entry loads.
    req_i = 4'b1000;
    gnt_i = 1'b0;
    #1; chk("r_empty_req_o", 32'(req_o), 32'd0);
        chk("r_empty_gnt",   32'(gnt_o), 32'b1000); tick();
    for (int k = 0; k < 2; k++) begin
      #1; chk("r_held_req_o", 32'(req_o), 32'd1);
          chk("r_held_id",    32'(id_o),  32'd3);
          chk("r_held_data",  data_o,     32'hA000_0003);
          chk("r_held_gnt",   32'(gnt_o), 32'd0); tick();
    end
    // Drain and accept in the same cycle; ptr = 0 after loading 3.
    req_i = 4'b0001;
    gnt_i = 1'b1;
    #1; chk("r_drain_gnt", 32'(gnt_o), 32'b0001);
        chk("r_drain_id",  32'(id_o),  32'd3); tick();
    // ptr = 1; full throughput with one cycle of latency.
    req_i = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      #1; chk("r_tp_id",  32'(id_o),  32'(k));
          chk("r_tp_gnt", 32'(gnt_o), 32'd1 << ((k + 1) % 4)); tick();
    end
    req_i = 4'b0000;
    #1; chk("r_last_id",  32'(id_o),  32'd0);
        chk("r_last_gnt", 32'(gnt_o), 32'd0); tick();
    #1; chk("r_empty2_req_o", 32'(req_o), 32'd0); tick();
    // Held entry discarded by reset.
    req_i = 4'b1000;
    gnt_i = 1'b0;
    tick();
    rst_n = 1'b0;
    #1; chk("r_rst_req_o", 32'(req_o), 32'd0);
    tick();
    rst_n = 1'b1;
    req_i = 4'b1100;
    #1; chk("r_post_rst_gnt", 32'(gnt_o), 32'b0100); tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
